brcomp_multicycle: RTL and testbench

BRCOMP_MULTICYCLE -- requirements
Module: brcomp_multicycle

---
 rtl/brcomp_multicycle.sv | 147 ++++++++++++++
 tb/tb_brcomp_multicycle.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/brcomp_multicycle.sv
// Chunk-serial RISC-V branch comparator: one CHUNK per cycle, MSB chunk first, result held in DONE.
// Latency 1..NCHUNK CMP cycles + 1; in_ready only in IDLE, result held until out_ready.
module brcomp_multicycle #(
  parameter int WIDTH      = 32,
  parameter int CHUNK      = 8,
  parameter int EARLY_EXIT = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] rs1_data,
  input  logic [WIDTH-1:0] rs2_data,
  input  logic [2:0]       br_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             br_less,
  output logic             br_equal,
  output logic             br_taken,
  output logic             br_illegal
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t            state_q, state_d;
  logic [WIDTH-1:0]  rs1_q, rs1_d, rs2_q, rs2_d;
  logic [2:0]        op_q, op_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic              diff_q, diff_d, lt_q, lt_d;
  logic              br_less_q, br_less_d, br_equal_q, br_equal_d;
  logic              br_taken_q, br_taken_d, br_illegal_q, br_illegal_d;

  logic              accept, op_in_illegal;
  logic [CHUNK-1:0]  chunk_a, chunk_b;
  logic              chunk_diff, fin_diff, fin_lt, last;

  assign accept        = in_valid && (state_q == IDLE);
  assign op_in_illegal = (br_op[2:1] == 2'b01);

  // Flipping both sign bits of the top chunk turns a signed compare into an unsigned one.
  always_comb begin
    chunk_a = rs1_q[int'(idx_q)*CHUNK +: CHUNK];
    chunk_b = rs2_q[int'(idx_q)*CHUNK +: CHUNK];
    if (!op_q[1] && (idx_q == IDXW'(NCHUNK-1))) begin
      chunk_a[CHUNK-1] = ~chunk_a[CHUNK-1];
      chunk_b[CHUNK-1] = ~chunk_b[CHUNK-1];
    end
  end

  assign chunk_diff = (chunk_a != chunk_b);
  assign fin_diff   = diff_q | chunk_diff;
  assign fin_lt     = diff_q ? lt_q : (chunk_diff && (chunk_a < chunk_b));
  assign last       = (idx_q == '0) || ((EARLY_EXIT != 0) && chunk_diff);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = op_in_illegal ? DONE : CMP;
      CMP:     if (last) state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
  end

  always_comb begin
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    op_d         = op_q;
    idx_d        = idx_q;
    diff_d       = diff_q;
    lt_d         = lt_q;
    br_less_d    = br_less_q;
    br_equal_d   = br_equal_q;
    br_taken_d   = br_taken_q;
    br_illegal_d = br_illegal_q;
    if (state_q == IDLE && accept) begin
      rs1_d  = rs1_data;
      rs2_d  = rs2_data;
      op_d   = br_op;
      idx_d  = IDXW'(NCHUNK-1);
      diff_d = 1'b0;
      lt_d   = 1'b0;
      if (op_in_illegal) begin
        br_less_d    = 1'b0;
        br_equal_d   = 1'b0;
        br_taken_d   = 1'b0;
        br_illegal_d = 1'b1;
      end
    end else if (state_q == CMP) begin
      diff_d = fin_diff;
      lt_d   = fin_lt;
      if (idx_q != '0) idx_d = idx_q - 1'b1;
      if (last) begin
        br_less_d    = fin_lt;
        br_equal_d   = !fin_diff;
        // op[2] selects the less-based ops; op[0] inverts the sense.
        br_taken_d   = op_q[2] ? (fin_lt ^ op_q[0]) : (!fin_diff ^ op_q[0]);
        br_illegal_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rs1_q        <= '0;
      rs2_q        <= '0;
      op_q         <= '0;
      idx_q        <= '0;
      diff_q       <= 1'b0;
      lt_q         <= 1'b0;
      br_less_q    <= 1'b0;
      br_equal_q   <= 1'b0;
      br_taken_q   <= 1'b0;
      br_illegal_q <= 1'b0;
    end else begin
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      op_q         <= op_d;
      idx_q        <= idx_d;
      diff_q       <= diff_d;
      lt_q         <= lt_d;
      br_less_q    <= br_less_d;
      br_equal_q   <= br_equal_d;
      br_taken_q   <= br_taken_d;
      br_illegal_q <= br_illegal_d;
    end
  end

  assign br_less    = br_less_q;
  assign br_equal   = br_equal_q;
  assign br_taken   = br_taken_q;
  assign br_illegal = br_illegal_q;

endmodule

// File: tb/tb_brcomp_multicycle.sv
// Directed bench: instance 0 with early exit, instance 1 always scanning all chunks.
module tb_brcomp_multicycle;

  logic        i_clk, i_rst_n, in_valid;
  logic [31:0] rs1_data, rs2_data;
  logic [2:0]  br_op;
  logic [1:0]  out_ready, in_ready, out_valid, br_less, br_equal, br_taken, br_illegal;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a, b;
    logic        less, eq, taken, ill;
    int          cyc;
  } vec_t;

  vec_t vecs[11];

  brcomp_multicycle #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(1)) u_ee (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .in_valid(in_valid), .in_ready(in_ready[0]),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .br_op(br_op),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .br_less(br_less[0]), .br_equal(br_equal[0]), .br_taken(br_taken[0]), .br_illegal(br_illegal[0]));

  brcomp_multicycle #(.WIDTH(32), .CHUNK(8), .EARLY_EXIT(0)) u_full (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .in_valid(in_valid), .in_ready(in_ready[1]),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .br_op(br_op),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .br_less(br_less[1]), .br_equal(br_equal[1]), .br_taken(br_taken[1]), .br_illegal(br_illegal[1]));

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_results(input string tag, input int d, input vec_t v);
    chk($sformatf("%s.u%0d.out_valid", tag, d), out_valid[d], 1'b1);
    chk($sformatf("%s.u%0d.in_ready", tag, d), in_ready[d], 1'b0);
    chk($sformatf("%s.u%0d.less", tag, d), br_less[d], v.less);
    chk($sformatf("%s.u%0d.equal", tag, d), br_equal[d], v.eq);
    chk($sformatf("%s.u%0d.taken", tag, d), br_taken[d], v.taken);
    chk($sformatf("%s.u%0d.illegal", tag, d), br_illegal[d], v.ill);
  endtask

  // Accept on both instances, scramble inputs, measure latency, hold 3 cycles, retire.
  task automatic run_vec(input string tag, input vec_t v);
    int cyc, lat0, lat1;
    chk({tag, ".idle_ready0"}, in_ready[0], 1'b1);
    chk({tag, ".idle_ready1"}, in_ready[1], 1'b1);
    rs1_data = v.a;
    rs2_data = v.b;
    br_op    = v.op;
    in_valid = 1'b1;
    @(posedge i_clk);
    #1;
    in_valid = 1'b0;
    rs1_data = ~v.a;
    rs2_data = v.a ^ 32'h5a5a_0001;
    br_op    = ~v.op;
    cyc = 1; lat0 = 0; lat1 = 0;
    for (int k = 0; k < 20; k++) begin
      if (out_valid[0] && lat0 == 0) lat0 = cyc;
      if (out_valid[1] && lat1 == 0) lat1 = cyc;
      if (lat0 != 0 && lat1 != 0) break;
      @(posedge i_clk);
      #1;
      cyc++;
    end
    chk({tag, ".latency_ee"}, lat0, v.cyc);
    chk({tag, ".latency_full"}, lat1, v.ill ? 1 : 5);
    for (int h = 0; h < 3; h++) begin
      chk_results($sformatf("%s.hold%0d", tag, h), 0, v);
      chk_results($sformatf("%s.hold%0d", tag, h), 1, v);
      @(posedge i_clk);
      #1;
    end
    chk_results({tag, ".pre_retire"}, 0, v);
    chk_results({tag, ".pre_retire"}, 1, v);
    out_ready = 2'b11;
    @(posedge i_clk);
    #1;
    out_ready = 2'b00;
    chk({tag, ".retired_valid"}, out_valid, 2'b00);
    chk({tag, ".retired_ready"}, in_ready, 2'b11);
  endtask

  initial begin
    // op, rs1, rs2, less, equal, taken, illegal, early-exit latency (cycles after acceptance)
    vecs[0]  = '{3'b000, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b1, 1'b1, 1'b0, 5};
    vecs[1]  = '{3'b100, 32'h8000_0000, 32'h0000_0001, 1'b1, 1'b0, 1'b1, 1'b0, 2};
    vecs[2]  = '{3'b110, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b0, 2};
    vecs[3]  = '{3'b101, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0, 1'b0, 1'b0, 5};
    vecs[4]  = '{3'b010, 32'h0000_0007, 32'h0000_0007, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[5]  = '{3'b011, 32'h1234_0000, 32'h0000_0001, 1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[6]  = '{3'b001, 32'h1234_5678, 32'h1234_5678, 1'b0, 1'b1, 1'b0, 1'b0, 5};
    vecs[7]  = '{3'b111, 32'hFFFF_0000, 32'h7FFF_0000, 1'b0, 1'b0, 1'b1, 1'b0, 2};
    vecs[8]  = '{3'b101, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0, 2};
    vecs[9]  = '{3'b100, 32'h0000_1000, 32'h0000_2000, 1'b1, 1'b0, 1'b1, 1'b0, 4};
    vecs[10] = '{3'b110, 32'h0002_0000, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 1'b0, 3};

    i_rst_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 2'b00;
    rs1_data  = '0;
    rs2_data  = '0;
    br_op     = '0;
    #12;
    chk("reset.out_valid", out_valid, 2'b00);
    chk("reset.less", br_less, 2'b00);
    chk("reset.equal", br_equal, 2'b00);
    chk("reset.taken", br_taken, 2'b00);
    chk("reset.illegal", br_illegal, 2'b00);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    chk("post_reset.in_ready", in_ready, 2'b11);

    for (int i = 0; i < 11; i++) run_vec($sformatf("vec%0d", i), vecs[i]);

    // Leave taken/equal at 1 so the abort check sees the reset clear them.
    run_vec("pre_abort", vecs[0]);
    rs1_data = 32'h0000_0001;
    rs2_data = 32'h0000_0002;
    br_op    = 3'b001;
    in_valid = 1'b1;
    @(posedge i_clk);
    #1;
    in_valid = 1'b0;
    @(posedge i_clk);
    #1;
    chk("abort.in_cmp_valid", out_valid, 2'b00);
    chk("abort.in_cmp_ready", in_ready, 2'b00);
    i_rst_n = 1'b0;
    #1;
    chk("abort.async_valid", out_valid, 2'b00);
    chk("abort.async_less", br_less, 2'b00);
    chk("abort.async_equal", br_equal, 2'b00);
    chk("abort.async_taken", br_taken, 2'b00);
    chk("abort.async_illegal", br_illegal, 2'b00);
    #3;
    i_rst_n = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(posedge i_clk);
      #1;
      chk($sformatf("abort.no_valid%0d", k), out_valid, 2'b00);
      chk($sformatf("abort.ready%0d", k), in_ready, 2'b11);
    end

    run_vec("recover", vecs[1]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time %0t, limit 200000", $time);
    $fatal(1);
  end

endmodule
